// File: rtl/bsg_arb_two_level_merge.sv
// Merge stage around bsg_arb_round_robin_two_level.
// Builds the arbiter's {high, low} request vector from prioritized sources.
// Captures the granted payload into a 2-entry in-order output FIFO.
// A starvation guard hides high requests once too many high grants in a row
// have gone by while a low source was waiting.
module bsg_arb_two_level_merge #(
  parameter int width_p        = 3,
  parameter int data_width_p   = 8,
  parameter int starve_limit_p = 4,
  localparam int src_width_lp    = (width_p > 1) ? $clog2(width_p) : 1,
  localparam int streak_width_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [width_p-1:0]              v_i,
  input  logic [width_p*data_width_p-1:0] data_i,
  input  logic [width_p-1:0]              hi_i,
  output logic [width_p-1:0]              yumi_o,
  output logic [2*width_p-1:0]            arb_reqs_o,
  input  logic [width_p-1:0]              arb_grants_i,
  input  logic                            arb_granted_high_i,
  output logic                            arb_yumi_o,
  output logic                            v_o,
  output logic [data_width_p-1:0]         data_o,
  output logic                            hi_o,
  output logic [src_width_lp-1:0]         src_id_o,
  input  logic                            ready_i
);

  localparam bit guard_en_lp = (starve_limit_p != 0);
  localparam logic [streak_width_lp-1:0] streak_max_lp = streak_width_lp'(starve_limit_p);

  logic [width_p-1:0]         low_reqs;
  logic [width_p-1:0]         high_reqs;
  logic                       low_pend;
  logic                       force_low;
  logic                       space;
  logic                       enq;
  logic                       deq;
  logic [1:0]                 count_r;
  logic [streak_width_lp-1:0] streak_r;
  logic                       rd_ptr_r;
  logic                       wr_ptr_r;
  logic [data_width_p-1:0]    data_mem_r [2];
  logic                       hi_mem_r   [2];
  logic [src_width_lp-1:0]    src_mem_r  [2];
  logic [data_width_p-1:0]    enq_data;
  logic [src_width_lp-1:0]    enq_src;

  // Request split; the high half is masked off while the guard is tripped.
  assign low_reqs   = v_i & ~hi_i;
  assign high_reqs  = v_i & hi_i;
  assign low_pend   = |low_reqs;
  assign force_low  = guard_en_lp && low_pend && (streak_r == streak_max_lp);
  assign arb_reqs_o = {high_reqs & {width_p{~force_low}}, low_reqs};

  // Enqueue only into a free slot; a same-cycle dequeue does not make room,
  // which keeps ready_i off the path to the sources' yumi.
  assign space      = (count_r < 2'd2);
  assign enq        = (|arb_grants_i) & space & ~reset_i;
  assign deq        = v_o & ready_i;
  assign arb_yumi_o = enq;
  assign yumi_o     = enq ? arb_grants_i : '0;

  // One-hot mux of the winning payload and encode of its source index.
  always_comb begin
    enq_data = '0;
    enq_src  = '0;
    for (int i = 0; i < width_p; i++) begin
      if (arb_grants_i[i]) begin
        enq_data = enq_data | data_i[i*data_width_p +: data_width_p];
        enq_src  = enq_src | src_width_lp'(i);
      end
    end
  end

  // FIFO occupancy and read/write pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  // FIFO storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_mem_r[wr_ptr_r] <= enq_data;
      hi_mem_r[wr_ptr_r]   <= arb_granted_high_i;
      src_mem_r[wr_ptr_r]  <= enq_src;
    end
  end

  // Count consecutive high enqueues while some low source is waiting.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_r <= '0;
    end else if (!low_pend) begin
      streak_r <= '0;
    end else if (enq && arb_granted_high_i) begin
      if (streak_r != streak_max_lp) streak_r <= streak_r + streak_width_lp'(1);
    end else if (enq) begin
      streak_r <= '0;
    end
  end

  assign v_o      = (count_r != 2'd0);
  assign data_o   = data_mem_r[rd_ptr_r];
  assign hi_o     = hi_mem_r[rd_ptr_r];
  assign src_id_o = src_mem_r[rd_ptr_r];

  a_grants_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(arb_grants_i));

  a_grants_requested: assert property (@(posedge clk_i) disable iff (reset_i)
    (arb_grants_i & ~(arb_reqs_o[width_p-1:0] | arb_reqs_o[2*width_p-1:width_p])) == '0);

  a_count_bound: assert property (@(posedge clk_i) count_r <= 2'd2);

endmodule

// File: tb/tb_bsg_arb_two_level_merge.sv
// Bench for bsg_arb_two_level_merge: two instances (guard limit 2 and guard
// disabled) share stimulus; a round-robin two-level arbiter model closes the
// loop, and a reference model feeds a per-instance scoreboard.
module tb_bsg_arb_two_level_merge;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [2:0]  v_i;
  logic [2:0]  hi_i;
  logic [23:0] data_i;
  logic        ready_i;

  logic [2:0]  yumi   [N];
  logic [5:0]  reqs   [N];
  logic [2:0]  grants [N];
  logic        gh     [N];
  logic        ayumi  [N];
  logic        vo     [N];
  logic [7:0]  dout   [N];
  logic        hout   [N];
  logic [1:0]  sid    [N];

  logic [1:0]  ptr_hi [N] = '{2'd2, 2'd2};
  logic [1:0]  ptr_lo [N] = '{2'd2, 2'd2};
  logic [1:0]  n_ptr_hi [N] = '{2'd2, 2'd2};
  logic [1:0]  n_ptr_lo [N] = '{2'd2, 2'd2};
  int          m_count  [N] = '{0, 0};
  int          m_streak [N] = '{0, 0};
  int          n_count  [N] = '{0, 0};
  int          n_streak [N] = '{0, 0};

  // entry layout: {hi, src[1:0], data[7:0]}
  logic [10:0] sb     [N][$];
  logic [10:0] outlog [N][$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] t3_src [6];
  logic       t3_hi  [6];
  logic [7:0] t4_data [7];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bsg_arb_two_level_merge #(
      .width_p       (3),
      .data_width_p  (8),
      .starve_limit_p((g == 0) ? 2 : 0)
    ) dut (
      .clk_i             (clk),
      .reset_i           (reset_i),
      .v_i               (v_i),
      .data_i            (data_i),
      .hi_i              (hi_i),
      .yumi_o            (yumi[g]),
      .arb_reqs_o        (reqs[g]),
      .arb_grants_i      (grants[g]),
      .arb_granted_high_i(gh[g]),
      .arb_yumi_o        (ayumi[g]),
      .v_o               (vo[g]),
      .data_o            (dout[g]),
      .hi_o              (hout[g]),
      .src_id_o          (sid[g]),
      .ready_i           (ready_i)
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Two-level round robin: any high request wins; search starts after last grant.
  function automatic logic [3:0] arbModel(input logic [5:0] r, input logic [1:0] ph, input logic [1:0] pl);
    logic [3:0] res;
    int idx;
    res = '0;
    if (|r[5:3]) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (int'(ph) + k) % 3;
        if (res[2:0] == 3'b000 && r[3+idx]) res[idx] = 1'b1;
      end
      res[3] = 1'b1;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        idx = (int'(pl) + k) % 3;
        if (res[2:0] == 3'b000 && r[idx]) res[idx] = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic int enc(input logic [2:0] g);
    return g[2] ? 2 : (g[1] ? 1 : 0);
  endfunction

  // Arbiter environment: grants are combinational from each DUT's requests.
  always_comb begin
    for (int g = 0; g < N; g++) begin
      {gh[g], grants[g]} = arbModel(reqs[g], ptr_hi[g], ptr_lo[g]);
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle with stable inputs.
  always @(negedge clk) begin
    logic [5:0]  er;
    logic [3:0]  ea;
    logic [2:0]  low_m;
    logic [10:0] head;
    logic        e_enq;
    logic        e_deq;
    logic        low_pend;
    logic        force_low;
    int          lim;
    int          s;
    for (int g = 0; g < N; g++) begin
      n_ptr_hi[g] = ptr_hi[g];
      n_ptr_lo[g] = ptr_lo[g];
      if (reset_i) begin
        checkOutput("rst_yumi", 32'(yumi[g]), 32'd0);
        checkOutput("rst_arb_yumi", 32'(ayumi[g]), 32'd0);
        n_count[g]  = 0;
        n_streak[g] = 0;
        n_ptr_hi[g] = 2'd2;
        n_ptr_lo[g] = 2'd2;
        sb[g].delete();
      end else begin
        lim       = (g == 0) ? 2 : 0;
        low_m     = v_i & ~hi_i;
        low_pend  = |low_m;
        force_low = (lim != 0) && low_pend && (m_streak[g] == lim);
        er        = {force_low ? 3'b000 : (v_i & hi_i), low_m};
        checkOutput("arb_reqs", 32'(reqs[g]), 32'(er));
        ea    = arbModel(er, ptr_hi[g], ptr_lo[g]);
        e_enq = (ea[2:0] != 3'b000) && (m_count[g] < 2);
        e_deq = (m_count[g] != 0) && ready_i;
        checkOutput("yumi", 32'(yumi[g]), e_enq ? 32'(ea[2:0]) : 32'd0);
        checkOutput("arb_yumi", 32'(ayumi[g]), 32'(e_enq));
        checkOutput("v_o", 32'(vo[g]), 32'(m_count[g] != 0));
        if (m_count[g] != 0) begin
          head = (sb[g].size() != 0) ? sb[g][0] : 11'h7ff;
          checkOutput("data_o", 32'(dout[g]), 32'(head[7:0]));
          checkOutput("hi_o", 32'(hout[g]), 32'(head[10]));
          checkOutput("src_id_o", 32'(sid[g]), 32'(head[9:8]));
          if (ready_i) begin
            outlog[g].push_back({hout[g], sid[g], dout[g]});
            if (sb[g].size() != 0) void'(sb[g].pop_front());
          end
        end
        if (e_enq) begin
          s = enc(ea[2:0]);
          sb[g].push_back({ea[3], 2'(s), data_i[s*8 +: 8]});
        end
        if (ayumi[g]) begin
          if (gh[g]) n_ptr_hi[g] = 2'(enc(grants[g]));
          else       n_ptr_lo[g] = 2'(enc(grants[g]));
        end
        n_count[g] = m_count[g] + int'(e_enq) - int'(e_deq);
        if (!low_pend)            n_streak[g] = 0;
        else if (e_enq && ea[3])  n_streak[g] = (m_streak[g] < lim) ? m_streak[g] + 1 : m_streak[g];
        else if (e_enq)           n_streak[g] = 0;
        else                      n_streak[g] = m_streak[g];
      end
    end
  end

  // Commit model and arbiter state on the active edge.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      m_count[g]  <= n_count[g];
      m_streak[g] <= n_streak[g];
      ptr_hi[g]   <= n_ptr_hi[g];
      ptr_lo[g]   <= n_ptr_lo[g];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [2:0] hi, input logic rdy);
    v_i     = v;
    hi_i    = hi;
    ready_i = rdy;
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    outlog[0].delete();
    outlog[1].delete();
  endtask

  initial begin
    t3_src  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    t3_hi   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    t4_data = '{8'h10, 8'h11, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    reset_i = 1'b1;
    data_i  = '0;
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick();
    tick();
    reset_i = 1'b0;

    // single low source, first-cycle yumi then next-cycle output
    data_i = {8'h33, 8'h22, 8'hA5};
    applyStimulus(3'b001, 3'b000, 1'b1);
    @(negedge clk);
    checkOutput("t1_yumi", 32'(yumi[0]), 32'b001);
    tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    @(negedge clk);
    checkOutput("t1_v_o", 32'(vo[0]), 32'd1);
    checkOutput("t1_data_o", 32'(dout[0]), 32'hA5);
    checkOutput("t1_hi_o", 32'(hout[0]), 32'd0);
    checkOutput("t1_src_id_o", 32'(sid[0]), 32'd0);
    tick();

    // guard disabled: the lone high source wins every cycle
    doReset();
    applyStimulus(3'b111, 3'b010, 1'b1);
    repeat (6) tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    tick();
    checkOutput("t2_count", 32'(outlog[1].size()), 32'd6);
    foreach (outlog[1][i]) begin
      checkOutput("t2_src", 32'(outlog[1][i][9:8]), 32'd1);
      checkOutput("t2_hi", 32'(outlog[1][i][10]), 32'd1);
    end

    // guard limit 2: H,H,L repeating
    doReset();
    applyStimulus(3'b111, 3'b110, 1'b1);
    repeat (6) tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    tick();
    checkOutput("t3_count", 32'(outlog[0].size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < outlog[0].size()) begin
        checkOutput("t3_src", 32'(outlog[0][i][9:8]), 32'(t3_src[i]));
        checkOutput("t3_hi", 32'(outlog[0][i][10]), 32'(t3_hi[i]));
      end
    end

    // backpressure fills the FIFO, then drain and steady enq+deq
    doReset();
    applyStimulus(3'b001, 3'b000, 1'b0);
    data_i[7:0] = 8'h10;
    @(negedge clk);
    checkOutput("t4_yumi_a", 32'(yumi[0]), 32'b001);
    tick();
    data_i[7:0] = 8'h11;
    @(negedge clk);
    checkOutput("t4_yumi_b", 32'(yumi[0]), 32'b001);
    tick();
    data_i[7:0] = 8'h12;
    @(negedge clk);
    checkOutput("t4_full_yumi", 32'(yumi[0]), 32'd0);
    checkOutput("t4_full_arb_yumi", 32'(ayumi[0]), 32'd0);
    checkOutput("t4_full_v_o", 32'(vo[0]), 32'd1);
    tick();
    ready_i = 1'b1;
    data_i[7:0] = 8'h13;
    @(negedge clk);
    checkOutput("t4_drain_yumi", 32'(yumi[0]), 32'd0);
    checkOutput("t4_drain_data", 32'(dout[0]), 32'h10);
    tick();
    data_i[7:0] = 8'h14;
    @(negedge clk);
    checkOutput("t4_resume_yumi", 32'(yumi[0]), 32'b001);
    checkOutput("t4_resume_data", 32'(dout[0]), 32'h11);
    tick();
    for (int i = 0; i < 4; i++) begin
      data_i[7:0] = 8'(8'h15 + i);
      @(negedge clk);
      checkOutput("t5_v_o", 32'(vo[0]), 32'd1);
      checkOutput("t5_yumi", 32'(yumi[0]), 32'b001);
      tick();
    end
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    tick();
    checkOutput("t4_count", 32'(outlog[0].size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < outlog[0].size()) checkOutput("t4_order", 32'(outlog[0][i][7:0]), 32'(t4_data[i]));
    end

    // reset with a full FIFO and a nonzero streak
    doReset();
    data_i = {8'h62, 8'h61, 8'h60};
    applyStimulus(3'b001, 3'b000, 1'b0);
    tick();
    applyStimulus(3'b011, 3'b010, 1'b0);
    tick();
    reset_i = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_yumi0", 32'(yumi[0]), 32'd0);
    checkOutput("t6_rst_yumi1", 32'(yumi[1]), 32'd0);
    checkOutput("t6_rst_arb_yumi", 32'(ayumi[0]), 32'd0);
    tick();
    reset_i = 1'b0;
    outlog[0].delete();
    outlog[1].delete();
    ready_i = 1'b1;
    @(negedge clk);
    checkOutput("t6_v_o0", 32'(vo[0]), 32'd0);
    checkOutput("t6_v_o1", 32'(vo[1]), 32'd0);
    repeat (3) tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    tick();
    checkOutput("t6_count", 32'(outlog[0].size()), 32'd3);
    if (outlog[0].size() == 3) begin
      checkOutput("t6_src0", 32'(outlog[0][0][9:8]), 32'd1);
      checkOutput("t6_src1", 32'(outlog[0][1][9:8]), 32'd1);
      checkOutput("t6_src2", 32'(outlog[0][2][9:8]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
